// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, reset constants, RV32 opcodes and fetch states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DROP  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_ifid.sv
// ============================================================================
//  Module      : ifid_reg
//  Description : IF/ID pipeline register with a one-entry stall hold buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifid_reg
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSN = cpu_pkg::NOP_INSN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            hold_valid,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [XLEN-1:0] ifid_instr,
    output logic [6:0]      ifid_opcode
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            hold_valid_q, hold_valid_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;

    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        pc4_d        = pc4_q;
        instr_d      = instr_q;
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        if (flush) begin
            // Bubble keeps the stale PC fields; only valid/instr are meaningful.
            valid_d      = 1'b0;
            instr_d      = NOP_INSN;
            hold_valid_d = 1'b0;
        end else if (stall) begin
            if (load) begin
                hold_valid_d = 1'b1;
                hold_pc_d    = load_pc;
                hold_instr_d = load_instr;
            end
        end else if (hold_valid_q) begin
            valid_d      = 1'b1;
            pc_d         = hold_pc_q;
            pc4_d        = hold_pc_q + XLEN'(4);
            instr_d      = hold_instr_q;
            hold_valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            pc4_d   = load_pc + XLEN'(4);
            instr_d = load_instr;
        end else begin
            valid_d = 1'b0;
            instr_d = NOP_INSN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            pc4_q        <= XLEN'(4);
            instr_q      <= NOP_INSN;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSN;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            pc4_q        <= pc4_d;
            instr_q      <= instr_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign hold_valid    = hold_valid_q;
    assign ifid_valid    = valid_q;
    assign ifid_pc       = pc_q;
    assign ifid_pc_plus4 = pc4_q;
    assign ifid_instr    = instr_q;
    assign ifid_opcode   = instr_q[6:0];

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : PC/fetch FSM with handshaked imem port feeding the IF/ID reg.
//                Optional macro FETCH_MISALIGN_TRAP_EN adds a misaligned-
//                redirect trap (fetch_fault output, FAULT state).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSN = cpu_pkg::NOP_INSN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [XLEN-1:0] ifid_instr,
    output logic [6:0]      ifid_opcode
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req;
    logic            accept;
    logic            flush;
    logic            hold_valid;
    logic [XLEN-1:0] target;
    logic            misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    assign target      = redirect_target;
    assign misaligned  = |redirect_target[1:0];
    assign fetch_fault = fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect_valid && misaligned) begin
            fault_q <= 1'b1;
        end
    end
`else
    logic unused_target_lsbs;

    assign target             = {redirect_target[XLEN-1:2], 2'b00};
    assign misaligned         = 1'b0;
    assign unused_target_lsbs = ^redirect_target[1:0];
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                req = !stall && !hold_valid;
                if (req && !imem_ready) begin
                    // Latch the address so it stays stable even if pc is redirected.
                    addr_d  = pc_q;
                    state_d = redirect_valid ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (imem_ready) begin
                    state_d = ST_RUN;
                end else if (redirect_valid) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                req = 1'b1;
                if (imem_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: flush = 1'b1;
            default:  state_d = ST_BOOT;
        endcase

        accept = req && imem_ready && !redirect_valid
               && ((state_q == ST_RUN) || (state_q == ST_WAIT));
        if (accept) begin
            pc_d = pc_q + XLEN'(4);
        end

        if (redirect_valid && (state_q != ST_FAULT)) begin
            flush = 1'b1;
            pc_d  = target;
            if (misaligned) begin
                state_d = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    assign imem_req  = req;
    assign imem_addr = ((state_q == ST_WAIT) || (state_q == ST_DROP)) ? addr_q : pc_q;

    ifid_reg #(
        .XLEN     (XLEN),
        .NOP_INSN (NOP_INSN)
    ) u_ifid (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .stall         (stall),
        .load          (accept),
        .load_pc       (pc_q),
        .load_instr    (imem_rdata),
        .hold_valid    (hold_valid),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_instr    (ifid_instr),
        .ifid_opcode   (ifid_opcode)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;
    logic [6:0]  ifid_opcode;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .ifid_valid      (ifid_valid),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .ifid_instr      (ifid_instr),
        .ifid_opcode     (ifid_opcode)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    // Instruction memory image: two fixed words, then addr-tagged addi encodings.
    function automatic logic [31:0] insn_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        if (a == 32'h4) return 32'h00B0_0113;
        return {a[19:0], 12'h013};
    endfunction

    assign imem_rdata = insn_at(imem_addr);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check_val({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, v});
        check_val({tag, ".pc"}, ifid_pc, pc);
        check_val({tag, ".pc4"}, ifid_pc_plus4, pc + 32'd4);
        check_val({tag, ".instr"}, ifid_instr, ins);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; imem_ready = 1'b1;
        repeat (2) step();

        // Reset state
        check_val("rst.req",    {31'b0, imem_req}, 32'd0);
        check_val("rst.addr",   imem_addr, 32'h0);
        check_val("rst.valid",  {31'b0, ifid_valid}, 32'd0);
        check_val("rst.pc",     ifid_pc, 32'h0);
        check_val("rst.pc4",    ifid_pc_plus4, 32'h4);
        check_val("rst.instr",  ifid_instr, 32'h0000_0013);
        check_val("rst.opcode", {25'b0, ifid_opcode}, 32'h13);

        // BOOT cycle, then streaming fetch with ready held high
        rst = 1'b0; #1;
        check_val("boot.req", {31'b0, imem_req}, 32'd0);
        step();
        check_val("run.req0",  {31'b0, imem_req}, 32'd1);
        check_val("run.addr0", imem_addr, 32'h0);
        step();
        check_ifid("if0", 1'b1, 32'h0, 32'h00A0_0093);
        check_val("if0.opcode", {25'b0, ifid_opcode}, 32'h13);
        check_val("run.addr4", imem_addr, 32'h4);
        step();
        check_ifid("if4", 1'b1, 32'h4, 32'h00B0_0113);

        // Memory wait of 3 cycles at 8
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("wait%0d.req", i), {31'b0, imem_req}, 32'd1);
            check_val($sformatf("wait%0d.addr", i), imem_addr, 32'h8);
            step();
            check_val($sformatf("wait%0d.valid", i), {31'b0, ifid_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        step();
        check_ifid("if8", 1'b1, 32'h8, 32'h0000_8013);

        // Response for 12 lands while stall is high: goes to the hold buffer
        imem_ready = 1'b0;
        step();
        imem_ready = 1'b1; stall = 1'b1; #1;
        check_val("hold.req_wait", {31'b0, imem_req}, 32'd1);
        check_val("hold.addr",     imem_addr, 32'hC);
        step();
        #1;
        check_val("hold.req_stall", {31'b0, imem_req}, 32'd0);
        check_val("hold.ifid_pc",   ifid_pc, 32'h8);
        check_val("hold.valid",     {31'b0, ifid_valid}, 32'd0);
        step();
        stall = 1'b0; #1;
        check_val("hold.req_drain", {31'b0, imem_req}, 32'd0);
        check_val("hold.ifid_pc2",  ifid_pc, 32'h8);
        step();
        check_ifid("if12", 1'b1, 32'hC, 32'h0000_C013);
        check_val("next.addr", imem_addr, 32'h10);
        check_val("next.req",  {31'b0, imem_req}, 32'd1);

        // Redirect to 0x40 while waiting on 0x10
        imem_ready = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_target = 32'h40; #1;
        check_val("drop.req0",  {31'b0, imem_req}, 32'd1);
        check_val("drop.addr0", imem_addr, 32'h10);
        step();
        redirect_valid = 1'b0; imem_ready = 1'b1; #1;
        check_val("drop.req1",   {31'b0, imem_req}, 32'd1);
        check_val("drop.addr1",  imem_addr, 32'h10);
        check_val("drop.valid1", {31'b0, ifid_valid}, 32'd0);
        step();
        check_val("drop.valid2", {31'b0, ifid_valid}, 32'd0);
        check_val("drop.addr2",  imem_addr, 32'h40);
        step();
        check_ifid("if40", 1'b1, 32'h40, 32'h0004_0013);

        // Redirect concurrent with stall flushes IF/ID
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100; #1;
        check_val("rdst.req", {31'b0, imem_req}, 32'd0);
        step();
        stall = 1'b0; redirect_valid = 1'b0; #1;
        check_val("rdst.valid", {31'b0, ifid_valid}, 32'd0);
        check_val("rdst.instr", ifid_instr, 32'h0000_0013);
        check_val("rdst.addr",  imem_addr, 32'h100);
        step();
        check_ifid("if100", 1'b1, 32'h100, 32'h0010_0013);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0; #1;
        check_val("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check_val("wrap.pc",   ifid_pc, 32'hFFFF_FFFC);
        check_val("wrap.pc4",  ifid_pc_plus4, 32'h0);
        check_val("wrap.next", imem_addr, 32'h0);

        // Back-to-back redirects: last target wins
        redirect_valid = 1'b1; redirect_target = 32'h200;
        step();
        redirect_target = 32'h300;
        step();
        redirect_valid = 1'b0; #1;
        check_val("b2b.addr",  imem_addr, 32'h300);
        check_val("b2b.valid", {31'b0, ifid_valid}, 32'd0);

        // Async reset pulse between edges while in WAIT
        imem_ready = 1'b0;
        step();
        check_val("arst.pre_addr", imem_addr, 32'h300);
        #2 rst = 1'b1; #1;
        check_val("arst.req",   {31'b0, imem_req}, 32'd0);
        check_val("arst.addr",  imem_addr, 32'h0);
        check_val("arst.valid", {31'b0, ifid_valid}, 32'd0);
        check_val("arst.instr", ifid_instr, 32'h0000_0013);
        check_val("arst.pc4",   ifid_pc_plus4, 32'h4);
        step();
        rst = 1'b0; imem_ready = 1'b1;
        step();

        // Misaligned redirect target
        redirect_valid = 1'b1; redirect_target = 32'h102;
        step();
        redirect_valid = 1'b0; #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        check_val("mis.fault", {31'b0, fetch_fault}, 32'd1);
        check_val("mis.req",   {31'b0, imem_req}, 32'd0);
        check_val("mis.valid", {31'b0, ifid_valid}, 32'd0);
        step();
        check_val("mis.fault2", {31'b0, fetch_fault}, 32'd1);
        check_val("mis.req2",   {31'b0, imem_req}, 32'd0);
`else
        check_val("mis.addr", imem_addr, 32'h100);
        check_val("mis.req",  {31'b0, imem_req}, 32'd1);
        step();
        check_ifid("if_mis", 1'b1, 32'h100, 32'h0010_0013);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
